// File: rtl/aurora_userk_pkg.sv
// aurora_userk_pkg: definitions shared by the Aurora UserK RX assembler and
// the UserK TX FSM. These are the lane count, the UserK word width and the
// receive FSM state encoding.
package aurora_userk_pkg;

    localparam int LANES  = 4;
    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        NOT_READY = 2'd0,
        IDLE      = 2'd1,
        COLLECT   = 2'd2
    } userk_state_e;

endpackage

// File: rtl/aurora_userk_lane_capture.sv
// aurora_userk_lane_capture: holds one lane's UserK word for the block being
// assembled, together with a flag that says whether the word has arrived.
// A load always wins over a clear. This lets a discarded block hand the
// same-cycle word straight into the fresh block.
module aurora_userk_lane_capture
    import aurora_userk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic              flag,
    output logic [WORD_W-1:0] word
);

    // Capture a word (setting the flag), or drop the flag when the block ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
            word <= '0;
        end else if (load) begin
            flag <= 1'b1;
            word <= data;
        end else if (clear) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/aurora_multilane_userk_rx.sv
// aurora_multilane_userk_rx: collects one UserK word per lane across four
// deskewed lanes. Each complete block is written into a downstream FIFO
// through a one-entry pending register.
// Optional feature: define AURORA_USERK_RX_ERRCNT_EN to build the saturating
// OverflowCnt / SkewErrCnt counters. Without it both outputs are tied to 0.
// DbgState exposes the FSM state (aurora_userk_pkg::userk_state_e encoding).
//
// FIFO handshake: FIFO_Full is the downstream "not ready" for the current
// cycle. FIFO_Write (and BlockRcvd) is asserted only when the pending register
// holds a block and FIFO_Full is low in that same cycle. That cycle is the
// transfer. FIFO_UserK is stable while the pending block waits.
module aurora_multilane_userk_rx
    import aurora_userk_pkg::*;
#(
    parameter int SKEW_MAX = 7,
    parameter int CNT_W    = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         LaneReady,
    input  logic [LANES-1:0]             RxUserKValid,
    input  logic [LANES-1:0][WORD_W-1:0] RxUserK,
    input  logic                         FIFO_Full,
    output logic                         FIFO_Write,
    output logic [LANES-1:0][WORD_W-1:0] FIFO_UserK,
    output logic                         BlockRcvd,
    output logic [CNT_W-1:0]             OverflowCnt,
    output logic [CNT_W-1:0]             SkewErrCnt,
    output logic [1:0]                   DbgState
);

    // The skew counter only has to hold 0..SKEW_MAX-1. At SKEW_MAX-1 the block
    // either completes or is discarded.
    localparam int SKEW_W = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;

    userk_state_e                 state;
    logic [SKEW_W-1:0]            skew_cnt;
    logic [LANES-1:0]             flags;
    logic [LANES-1:0][WORD_W-1:0] words;
    logic                         pend_valid;
    logic [LANES-1:0][WORD_W-1:0] pend_data;

    logic                         active;
    logic [LANES-1:0]             valid;
    logic                         dup;
    logic                         cont_done;
    logic                         timeout;
    logic                         discard;
    logic [LANES-1:0]             base_flags;
    logic [LANES-1:0]             next_flags;
    logic                         complete;
    logic                         drain;
    logic                         clear;
    logic [LANES-1:0][WORD_W-1:0] merged;

    // Per-cycle decision: continue, complete, or discard the partial block.
    always_comb begin
        active     = LaneReady && (state != NOT_READY);
        valid      = active ? RxUserKValid : '0;
        dup        = |(valid & flags);
        cont_done  = !dup && ((flags | valid) == '1);
        timeout    = (state == COLLECT) && (skew_cnt == SKEW_W'(SKEW_MAX - 1));
        // Completion beats timeout. A duplicate always discards.
        discard    = active && (dup || (timeout && !cont_done));
        // After a discard, this cycle's words seed a fresh block.
        base_flags = discard ? '0 : flags;
        next_flags = base_flags | valid;
        complete   = active && (next_flags == '1);
        for (int n = 0; n < LANES; n++) begin
            merged[n] = valid[n] ? RxUserK[n] : words[n];
        end
        drain      = pend_valid && !FIFO_Full;
    end

    assign clear = !LaneReady || complete || discard;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        aurora_userk_lane_capture u_capture (
            .clk   (Clk),
            .rst_n (Rst),
            .clear (clear),
            .load  (valid[n] && !complete),
            .data  (RxUserK[n]),
            .flag  (flags[n]),
            .word  (words[n])
        );
    end

    // FSM and skew counter. Losing LaneReady forces NOT_READY from any state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= NOT_READY;
            skew_cnt <= '0;
        end else if (!LaneReady) begin
            state    <= NOT_READY;
            skew_cnt <= '0;
        end else if (state == NOT_READY) begin
            state    <= IDLE;
            skew_cnt <= '0;
        end else if (complete || (next_flags == '0)) begin
            state    <= IDLE;
            skew_cnt <= '0;
        end else begin
            state    <= COLLECT;
            skew_cnt <= (base_flags == '0) ? '0 : skew_cnt + 1'b1;
        end
    end

    // Pending register. A draining entry frees the slot for a same-cycle completion.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (complete && (!pend_valid || drain)) begin
            pend_valid <= 1'b1;
            pend_data  <= merged;
        end else if (drain) begin
            pend_valid <= 1'b0;
        end
    end

    assign FIFO_Write = drain;
    assign BlockRcvd  = drain;
    assign FIFO_UserK = pend_data;
    assign DbgState   = state;

`ifdef AURORA_USERK_RX_ERRCNT_EN
    logic             overflow;
    logic [CNT_W-1:0] overflow_cnt;
    logic [CNT_W-1:0] skew_err_cnt;

    assign overflow = complete && pend_valid && FIFO_Full;

    // Saturating error counters: dropped blocks and discarded partial blocks.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            overflow_cnt <= '0;
            skew_err_cnt <= '0;
        end else begin
            if (overflow && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
            if (discard && (skew_err_cnt != '1)) begin
                skew_err_cnt <= skew_err_cnt + 1'b1;
            end
        end
    end

    assign OverflowCnt = overflow_cnt;
    assign SkewErrCnt  = skew_err_cnt;
`else
    assign OverflowCnt = '0;
    assign SkewErrCnt  = '0;
`endif

endmodule

// File: tb/tb_aurora_multilane_userk_rx.sv
// tb_aurora_multilane_userk_rx: directed and randomized stimulus for the
// Aurora UserK block assembler. The reference model tracks which lanes have
// arrived, the age of the partial block, and a one-deep pending queue.
`timescale 1ns/1ps
module tb_aurora_multilane_userk_rx;
    import aurora_userk_pkg::*;

    localparam int SKEW_MAX = 7;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef AURORA_USERK_RX_ERRCNT_EN
    localparam logic [CNT_W-1:0] ERR_MASK = '1;
`else
    localparam logic [CNT_W-1:0] ERR_MASK = '0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             Clk = 1'b0;
    logic             Rst;
    logic             LaneReady;
    logic [3:0]       RxUserKValid;
    logic [3:0][63:0] RxUserK;
    logic             FIFO_Full;
    logic             FIFO_Write;
    logic [3:0][63:0] FIFO_UserK;
    logic             BlockRcvd;
    logic [CNT_W-1:0] OverflowCnt;
    logic [CNT_W-1:0] SkewErrCnt;
    logic [1:0]       DbgState;

    always #5 Clk = ~Clk;

    aurora_multilane_userk_rx #(.SKEW_MAX(SKEW_MAX), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .LaneReady    (LaneReady),
        .RxUserKValid (RxUserKValid),
        .RxUserK      (RxUserK),
        .FIFO_Full    (FIFO_Full),
        .FIFO_Write   (FIFO_Write),
        .FIFO_UserK   (FIFO_UserK),
        .BlockRcvd    (BlockRcvd),
        .OverflowCnt  (OverflowCnt),
        .SkewErrCnt   (SkewErrCnt),
        .DbgState     (DbgState)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic       wr;
        int         ov;
        int         se;
        logic [1:0] st;
    } cyc_rec_t;

    logic [255:0] exp_q[$];
    cyc_rec_t     cyc_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           in_reset = 1'b1;

    // ---------------- reference model state ----------------
    bit               m_conn;
    logic [3:0]       m_have;
    logic [3:0][63:0] m_word;
    int               m_first;
    int               m_cyc;
    int               m_ov;
    int               m_se;
    logic [255:0]     m_pend[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt(input int c);
        return CNT_W'(c) & ERR_MASK;
    endfunction

    function automatic logic [3:0][63:0] rnd_data();
        logic [3:0][63:0] d;
        for (int n = 0; n < 4; n++) d[n] = {$urandom, $urandom};
        return d;
    endfunction

    task automatic model_reset();
        m_conn  = 1'b0;
        m_have  = '0;
        m_word  = '0;
        m_first = 0;
        m_cyc   = 0;
        m_ov    = 0;
        m_se    = 0;
        m_pend.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    // One cycle of the behavioural model. The inputs are those applied in this cycle.
    task automatic model_step(input logic lr, input logic [3:0] v, input logic [3:0][63:0] d,
                              input logic full);
        cyc_rec_t         r;
        bit               dup;
        bit               all_set;
        bit               done;
        logic [3:0][63:0] blk;
        r.wr = (m_pend.size() != 0) && !full;
        r.ov = m_ov;
        r.se = m_se;
        r.st = !m_conn ? NOT_READY : ((m_have != 0) ? COLLECT : IDLE);
        cyc_q.push_back(r);
        if (r.wr) exp_q.push_back(m_pend.pop_front());
        done = 1'b0;
        blk  = '0;
        if (!lr) begin
            m_have = '0;
            m_conn = 1'b0;
        end else if (!m_conn) begin
            m_conn = 1'b1;
        end else begin
            dup     = 1'b0;
            all_set = 1'b1;
            for (int n = 0; n < 4; n++) begin
                if (v[n] && m_have[n]) dup = 1'b1;
                if (!(v[n] || m_have[n])) all_set = 1'b0;
            end
            if (!dup && all_set) begin
                for (int n = 0; n < 4; n++) blk[n] = v[n] ? d[n] : m_word[n];
                done   = 1'b1;
                m_have = '0;
            end else begin
                if ((m_have != 0) && (dup || (m_cyc - m_first == SKEW_MAX))) begin
                    if (m_se < CNT_MAX) m_se++;
                    m_have = '0;
                end
                if ((v != 0) && (m_have == 0)) m_first = m_cyc;
                for (int n = 0; n < 4; n++) begin
                    if (v[n]) begin
                        m_have[n] = 1'b1;
                        m_word[n] = d[n];
                    end
                end
                if (m_have == 4'hF) begin
                    blk    = m_word;
                    done   = 1'b1;
                    m_have = '0;
                end
            end
        end
        if (done) begin
            if (m_pend.size() == 0) m_pend.push_back(blk);
            else if (m_ov < CNT_MAX) m_ov++;
        end
        m_cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic lr, input logic [3:0] v, input logic [3:0][63:0] d,
                         input logic full);
        @(posedge Clk);
        #1;
        Rst          = 1'b1;
        in_reset     = 1'b0;
        LaneReady    = lr;
        RxUserKValid = v;
        RxUserK      = d;
        FIFO_Full    = full;
        model_step(lr, v, d, full);
    endtask

    task automatic idle(input int cycles, input logic full);
        for (int i = 0; i < cycles; i++) drive(1'b1, 4'h0, rnd_data(), full);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fifo_write"}, FIFO_Write, 0);
        check({tag, "_block_rcvd"}, BlockRcvd, 0);
        check({tag, "_fifo_userk"}, FIFO_UserK, 0);
        check({tag, "_overflow_cnt"}, OverflowCnt, 0);
        check({tag, "_skew_err_cnt"}, SkewErrCnt, 0);
        check({tag, "_state"}, DbgState, NOT_READY);
    endtask

    task automatic apply_reset();
        @(posedge Clk);
        #1;
        Rst          = 1'b0;
        in_reset     = 1'b1;
        LaneReady    = 1'b0;
        RxUserKValid = '0;
        FIFO_Full    = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge Clk);
        #1;
        check_zero("rst_held");
    endtask

    // ---------------- monitor ----------------
    initial begin
        cyc_rec_t r;
        forever begin
            @(negedge Clk);
            if (!in_reset && (cyc_q.size() != 0)) begin
                r = cyc_q.pop_front();
                check("fifo_write", FIFO_Write, r.wr);
                check("block_rcvd", BlockRcvd, r.wr);
                check("overflow_cnt", OverflowCnt, exp_cnt(r.ov));
                check("skew_err_cnt", SkewErrCnt, exp_cnt(r.se));
                check("state", DbgState, r.st);
                if (FIFO_Write === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got block %0h expected no write", FIFO_UserK);
                    end else begin
                        check("fifo_userk", FIFO_UserK, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0][63:0] d;
        logic [3:0]       v;
        Rst          = 1'b0;
        LaneReady    = 1'b0;
        RxUserKValid = '0;
        RxUserK      = '0;
        FIFO_Full    = 1'b0;
        model_reset();
        apply_reset();

        // Connect, then all four lanes in one cycle with A0..A3.
        idle(10, 1'b0);
        d[0] = 64'hA0; d[1] = 64'hA1; d[2] = 64'hA2; d[3] = 64'hA3;
        drive(1'b1, 4'hF, d, 1'b0);
        idle(3, 1'b0);

        // Skewed block: lanes 0,1 then lanes 2,3 three cycles later.
        drive(1'b1, 4'h3, rnd_data(), 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 4'hC, rnd_data(), 1'b0);
        idle(3, 1'b0);

        // Lone lane 0 times out.
        drive(1'b1, 4'h1, rnd_data(), 1'b0);
        idle(10, 1'b0);

        // Last lane arriving exactly SKEW_MAX cycles after the first still completes.
        drive(1'b1, 4'h7, rnd_data(), 1'b0);
        idle(SKEW_MAX - 1, 1'b0);
        drive(1'b1, 4'h8, rnd_data(), 1'b0);
        idle(3, 1'b0);

        // Timeout and a new word in the same cycle.
        drive(1'b1, 4'h1, rnd_data(), 1'b0);
        idle(SKEW_MAX - 1, 1'b0);
        drive(1'b1, 4'h4, rnd_data(), 1'b0);
        drive(1'b1, 4'hB, rnd_data(), 1'b0);
        idle(3, 1'b0);

        // FIFO full: three blocks complete, then the FIFO frees up.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, rnd_data(), 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);

        // Duplicate on lane 1 restarts the block, which then completes.
        drive(1'b1, 4'h2, rnd_data(), 1'b0);
        drive(1'b1, 4'h1, rnd_data(), 1'b0);
        drive(1'b1, 4'h2, rnd_data(), 1'b0);
        drive(1'b1, 4'hD, rnd_data(), 1'b0);
        idle(3, 1'b0);

        // Pending survives loss of LaneReady and is still written.
        drive(1'b1, 4'hF, rnd_data(), 1'b1);
        drive(1'b1, 4'h3, rnd_data(), 1'b1);
        drive(1'b0, 4'hC, rnd_data(), 1'b1);
        drive(1'b0, 4'h0, rnd_data(), 1'b0);
        idle(4, 1'b0);

        // LaneReady drop mid-collect, then reset.
        drive(1'b1, 4'h5, rnd_data(), 1'b0);
        drive(1'b0, 4'h0, rnd_data(), 1'b0);
        apply_reset();
        idle(2, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 4; n++) v[n] = ($urandom_range(0, 99) < 35);
            drive(($urandom_range(0, 99) < 97), v, rnd_data(), ($urandom_range(0, 99) < 25));
        end

        // Drain and confirm nothing is left outstanding.
        idle(6, 1'b0);
        @(negedge Clk);
        #1;
        check("leftover_blocks", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aurora_multilane_userk_rx.md
AURORA_MULTILANE_USERK_RX -- requirements
Module: aurora_multilane_userk_rx

Interface
REQ-001 Parameter SKEW_MAX, default 7: maximum cycles between the first and last lane UserK word of one block.
REQ-002 Parameter CNT_W, default 8: width of each error counter.
REQ-003 Clk  input  1  single block clock; all logic is on its rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-low.
REQ-005 LaneReady  input  1  channel up; all four lanes are aligned.
REQ-006 RxUserKValid  input  4  per-lane strobe; one decoded UserK word is present on that lane this cycle.
REQ-007 RxUserK  input  [3:0][63:0]  per-lane UserK payload; valid only with its strobe.
REQ-008 FIFO_Full  input  1  downstream FIFO cannot accept a write this cycle.
REQ-009 FIFO_Write  output  1  one-cycle write strobe.
REQ-010 FIFO_UserK  output  [3:0][63:0]  assembled block; lane n maps to slice n.
REQ-011 BlockRcvd  output  1  one-cycle pulse per block accepted into the FIFO.
REQ-012 OverflowCnt  output  CNT_W  saturating count of blocks dropped because the FIFO was full.
REQ-013 SkewErrCnt  output  CNT_W  saturating count of partial blocks discarded (timeout or duplicate lane).

Function
REQ-014 FSM states SHALL be NOT_READY, IDLE, COLLECT.
- NOT_READY -> IDLE when LaneReady=1.
- IDLE -> COLLECT on any RxUserKValid bit.
- COLLECT -> IDLE on completion or discard.
- Any state -> NOT_READY whenever LaneReady=0.
REQ-015 A per-lane captured flag and a 64-bit word SHALL be held. A block is complete in the cycle the fourth flag would be set; all four lanes in one cycle complete directly from IDLE.
REQ-016 Skew counter SHALL start at 0 on the first captured word and increment each COLLECT cycle. When it reaches SKEW_MAX without completion: discard the partial block, increment SkewErrCnt, go to IDLE.
REQ-017 Valid on an already-captured lane SHALL discard the partial block and increment SkewErrCnt. The new word(s) that cycle then start a fresh block, with the skew counter at 0.
REQ-018 Timeout and new valid words in the same cycle: timeout applies to the old partial; the new words start a fresh block.
REQ-019 Completion in cycle N with FIFO_Full=0 and pending empty SHALL give FIFO_Write=1 and BlockRcvd=1 in cycle N+1, with FIFO_UserK holding the block.
REQ-020 One-entry pending register:
- A completed block that cannot be written goes to pending.
- Pending is written on the first cycle FIFO_Full=0, before any newer block, preserving order.
REQ-021 A block completing while pending is full and FIFO_Full=1 SHALL be dropped, and OverflowCnt incremented. If pending drains in that same cycle, the new block moves into pending instead.
REQ-022 LaneReady=0 SHALL clear all captured flags and the skew counter; the pending block is kept and still written.
REQ-023 Counters SHALL saturate at all-ones and never wrap.
REQ-024 FIFO_Write SHALL never assert while FIFO_Full=1 in the same cycle.

Reset
REQ-025 On Rst=0, asynchronously: state NOT_READY; flags, skew counter, pending-valid cleared; FIFO_Write=0, BlockRcvd=0, FIFO_UserK=0, OverflowCnt=0, SkewErrCnt=0.
REQ-026 Reset mid-block SHALL discard partial and pending data without incrementing any counter.

Configuration
REQ-027 With AURORA_USERK_RX_ERRCNT_EN defined: OverflowCnt and SkewErrCnt SHALL count as specified.
REQ-028 Without AURORA_USERK_RX_ERRCNT_EN: both outputs SHALL be constant 0, no counter flops exist, and drop/discard behaviour is unchanged.

Structure
REQ-029 The state enum, lane count (4) and UserK word width (64) SHALL live in shared package aurora_userk_pkg, also used by the TX FSM.
REQ-030 Per-lane capture (flag + word register) SHALL be sub-module aurora_userk_lane_capture, instantiated four times.

Verification
REQ-031 All four valids in cycle 10 with payload 64'hA0..A3 -> FIFO_Write=1 and BlockRcvd=1 in cycle 11, FIFO_UserK={A3,A2,A1,A0}.
REQ-032 Lanes 0,1 valid in cycle 0; lanes 2,3 valid in cycle 3 (SKEW_MAX=7) -> one write in cycle 4; SkewErrCnt stays 0.
REQ-033 Lane 0 valid in cycle 0 only -> discard after 7 cycles; SkewErrCnt=1; no write.
REQ-034 FIFO_Full=1; blocks B1, B2, B3 complete; then FIFO_Full=0 -> B1 written; B2, B3 dropped; OverflowCnt=2.
REQ-035 Lane 1 valid twice during COLLECT -> SkewErrCnt=1; second word starts a new block, which completes normally.
REQ-036 LaneReady=0 mid-COLLECT, then Rst=0 pulse -> no write; all outputs 0; state NOT_READY.
